div_seq: RTL
============

Name: div_seq

Overview:
- Iterative radix-2 restoring divider for the M-extension execute stage.
- Implements DIV, DIVU, REM and REMU, plus the word forms DIVW, DIVUW, REMW and REMUW.
- It is the inverse datapath of the combinational multiplier slices and sits beside them under M.
- Accepts one operation at a time and returns the result with a one-cycle ready pulse, so execute stalls while BUSY is high.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  start request; sampled only in IDLE.
- KILL  input  1  pipeline flush; aborts the operation in flight.
- OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- WORD  input  1  1 selects the 32-bit W form.
- RS1  input  XLEN  dividend.
- RS2  input  XLEN  divisor.
- BUSY  output  1  high from the accept edge until RDY_D.
- RDY_D  output  1  one-cycle pulse; RESULT is valid while it is high.
- RESULT  output  XLEN  quotient or remainder.

Behaviour:
- Reset: state=IDLE; BUSY, RDY_D and RESULT all 0; internal quotient, remainder and counter registers cleared. Reset asserted mid-operation discards that operation, and no RDY_D follows.
- States: IDLE, ITER, FIX, DONE.
- Accept: an edge in IDLE with EN=1 and KILL=0. Operands are latched at that edge; RS1/RS2/OP/WORD are don't-care afterwards. EN in any other state is ignored, with no queueing.
- Operand preparation (combinational, in IDLE):
  - Signed is OP[0]=0.
  - For WORD=1, use RS1[31:0] and RS2[31:0], sign-extended if signed, zero-extended otherwise.
  - For signed ops, store the magnitudes, plus neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
- Special cases (decided at accept; go directly to DONE, so RDY_D arrives 1 edge after accept):
  - Divisor zero: quotient = all ones; remainder = extended dividend.
  - Signed overflow (dividend is the most negative value of the active width, divisor = -1): quotient = dividend; remainder = 0.
- ITER:
  - Counter loads 63 for XLEN ops, or 31 for WORD ops.
  - Each edge performs one restoring step: shift {rem, quo} left by 1; trial = rem - divisor; if trial is non-negative, rem = trial and quo LSB = 1.
  - When the counter reaches 0, move to FIX.
- FIX: conditionally negate quo with neg_q and rem with neg_r, select by OP[1], then go to DONE.
- DONE:
  - RESULT is registered; RDY_D=1 for exactly one cycle.
  - For WORD=1, RESULT = sign-extend of bit 31 for every W op, including DIVUW and REMUW.
  - Next edge returns to IDLE. BUSY=0 in DONE, so EN is accepted in the DONE+1 cycle.
- Latency from accept edge to RDY_D:
  - 66 edges for XLEN ops (64 ITER + FIX + DONE entry).
  - 34 edges for WORD ops.
  - 1 edge for special cases.
- RESULT holds its last value after RDY_D until the next DONE.
- KILL in ITER or FIX: next state is IDLE, BUSY falls next edge, and no RDY_D.
- KILL in DONE: RDY_D is still presented, since that result already retired to the bypass.
- KILL and EN together in IDLE: not accepted.
- Arithmetic: the remainder path is XLEN+1 bits wide to hold the trial subtraction sign; all other arithmetic is modulo 2^XLEN.

Decomposition:
- Package div_pkg holds:
  - the div_op_e enum (DIV, DIVU, REM, REMU);
  - the div_state_e enum (IDLE, ITER, FIX, DONE);
  - the ITER_XLEN=63 and ITER_W=31 constants;
  - the XLEN default.
- Sub-module div_step: combinational single restoring iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is instantiated once in div_seq.

Test Plan:
- DIVU: RS1=100, RS2=7. Expect RDY_D 66 edges after accept, RESULT=14; with REMU, RESULT=2. BUSY high throughout.
- DIV/REM with RS1=-7, RS2=2:
  - DIV gives RESULT=0xFFFF_FFFF_FFFF_FFFD (-3).
  - REM gives 0xFFFF_FFFF_FFFF_FFFF (-1).
  - RS1=7, RS2=-2 with REM gives 1.
- Divide by zero, RS1=5, RS2=0:
  - DIVU gives 0xFFFF_FFFF_FFFF_FFFF.
  - REMU gives 5.
  - RDY_D arrives 1 edge after accept.
- Overflow: DIV with RS1=0x8000_0000_0000_0000, RS2=-1 gives 0x8000_0000_0000_0000; REM gives 0. Latency is 1.
- DIVW with RS1=0x0000_0001_FFFF_FFF9, RS2=2:
  - Expect 0xFFFF_FFFF_FFFF_FFFD at 34 edges.
  - DIVUW with RS1=0x8000_0000, RS2=1 gives 0xFFFF_FFFF_8000_0000.
- Abort and reset:
  - Assert KILL on the 10th ITER cycle: BUSY drops next edge, no RDY_D, and an EN two cycles later is accepted and completes normally.
  - Pulse RST_N low mid-ITER: outputs go to 0 immediately and no RDY_D follows.
  - EN asserted while BUSY is ignored.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// div_op_e    : OP encoding (DIV, DIVU, REM, REMU); bit 0 = unsigned, bit 1 = remainder.
// div_state_e : divider control states.
// ITER_XLEN / ITER_W : counter load values for full-width and W-form operations.
package div_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int ITER_XLEN    = 63;
    localparam int ITER_W       = 31;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// rem      : partial remainder, XLEN+1 bits
// quo      : dividend bits still to shift in, low bits collect quotient
// divisor  : divisor magnitude
// rem_nxt  : partial remainder after the step
// quo_nxt  : quotient/dividend register after the step
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    always_comb begin
        // Shift the next dividend bit into the remainder; the extra top bit
        // of trial carries the borrow so a negative trial is detectable.
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {2'b00, divisor};
        if (trial[XLEN+1]) begin
            rem_nxt = shifted[XLEN:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt = trial[XLEN:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W forms.
// CLK, RST_N  : clock, asynchronous active-low reset
// EN, KILL    : start request (sampled in IDLE), pipeline flush
// OP, WORD    : operation select, 32-bit W form select
// RS1, RS2    : dividend, divisor (latched at accept)
// BUSY        : high while iterating / fixing sign
// RDY_D       : one-cycle pulse, RESULT valid while high
// RESULT      : quotient or remainder, held until the next completion
module div_seq
    import div_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 7
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            KILL,
    input  logic [1:0]      OP,
    input  logic            WORD,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            BUSY,
    output logic            RDY_D,
    output logic [XLEN-1:0] RESULT
);

    div_state_e        state_q, state_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              rem_sel_q, rem_sel_d;
    logic              word_q, word_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand preparation
    div_op_e           op_in;
    logic              signed_op, rem_op;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_neg;
    logic              a_neg, b_neg, div_zero, ovf;

    // Sign fix-up
    logic [XLEN-1:0]   q_fix, r_fix;

    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quo;

    // W forms always return bit 31 sign-extended, even for unsigned ops.
    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    div_step #(.XLEN(XLEN)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    always_comb begin
        op_in     = div_op_e'(OP);
        signed_op = (op_in == DIV) || (op_in == REM);
        rem_op    = (op_in == REM) || (op_in == REMU);
        a_ext = WORD ? {{(XLEN-32){signed_op & RS1[31]}}, RS1[31:0]} : RS1;
        b_ext = WORD ? {{(XLEN-32){signed_op & RS2[31]}}, RS2[31:0]} : RS2;
        a_neg = signed_op & a_ext[XLEN-1];
        b_neg = signed_op & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        // Most negative value of the active width, in extended form.
        min_neg  = WORD ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = signed_op && (a_ext == min_neg) && (b_ext == '1);
        q_fix = neg_q_q ? -quo_q : quo_q;
        r_fix = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        rem_sel_d = rem_sel_q;
        word_d    = word_q;
        result_d  = result_q;
        rdy_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (EN && !KILL) begin
                    rem_sel_d = rem_op;
                    word_d    = WORD;
                    neg_q_d   = a_neg ^ b_neg;
                    neg_r_d   = a_neg;
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    // W forms run 32 steps, so park the dividend in the top half.
                    quo_d     = WORD ? (a_mag << 32) : a_mag;
                    cnt_d     = WORD ? CNT_W'(ITER_W) : CNT_W'(ITER_XLEN);
                    if (div_zero) begin
                        result_d = word_fix(rem_op ? a_ext : '1, WORD);
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = word_fix(rem_op ? '0 : a_ext, WORD);
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (KILL)
                    state_d = IDLE;
                else if (cnt_q == '0)
                    state_d = FIX;
            end
            FIX: begin
                if (KILL) begin
                    state_d = IDLE;
                end else begin
                    result_d = word_fix(rem_sel_q ? r_fix : q_fix, word_q);
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Result already retired; KILL here does not retract it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ITER) || (state_d == FIX);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            rem_sel_q <= rem_sel_d;
            word_q    <= word_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            result_q  <= result_d;
        end
    end

    assign BUSY   = busy_q;
    assign RDY_D  = rdy_q;
    assign RESULT = result_q;

endmodule
